// File: rtl/exe_decode_lanes_pkg.sv
// Shared decode types: micro-opcodes, immediate formats, ALU/branch control
// and the ROB age compare used for branch-kill squashing.
package uopc;
  typedef enum logic [5:0] {
    uop_nop, uop_lui, uop_auipc, uop_addi, uop_slti, uop_sltiu, uop_xori,
    uop_ori, uop_andi, uop_slli, uop_srli, uop_srai, uop_add, uop_sub,
    uop_sll, uop_slt, uop_sltu, uop_xor, uop_srl, uop_sra, uop_or, uop_and,
    uop_beq, uop_bne, uop_blt, uop_bge, uop_bltu, uop_bgeu, uop_jal,
    uop_jalr, uop_lw, uop_sw
  } micro_opcode_t;
endpackage

package immt;
  typedef enum logic [2:0] {imm_i, imm_s, imm_b, imm_u, imm_j} imm_type_t;
endpackage

package alufnt;
  typedef enum logic [3:0] {
    alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
    alu_xor, alu_srl, alu_sra, alu_or, alu_and
  } alu_func_t;
endpackage

package opr2t;
  typedef enum logic {opr2_rs2, opr2_imm} operand2_t;
endpackage

package brfnt;
  typedef enum logic [2:0] {
    br_none, br_beq, br_bne, br_blt, br_bge, br_bltu, br_bgeu, br_jalr
  } br_func_t;
endpackage

package rv32i_types;
  typedef struct packed {
    alufnt::alu_func_t alufn;
    opr2t::operand2_t  opr2;
    brfnt::br_func_t   brfn;
  } exe_ctrl_t;

  // lane_pass: skid empty, input accepted; lane_skid: skid holds an op
  typedef enum logic {lane_pass, lane_skid} lane_state_t;

  // True when idx is strictly younger than other_idx, ages taken relative to
  // head modulo 2^w so the compare wraps with the ROB.
  function automatic logic rob_younger(input logic [31:0] idx,
                                       input logic [31:0] other_idx,
                                       input logic [31:0] head,
                                       input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((idx - head) & mask) > ((other_idx - head) & mask);
  endfunction
endpackage

// File: rtl/exe_decode_lanes_lane.sv
// One execute-decode lane: opcode/immediate decode, output register and a
// one-entry skid buffer, with in-place flush and branch-kill squashing.
module exe_dec_lane
  import rv32i_types::*;
  import uopc::*;
  import immt::*;
  import alufnt::*;
  import opr2t::*;
  import brfnt::*;
#(
  parameter int ROB_IDX_W = 5,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROB_IDX_W-1:0] rob_head,
  input  logic                 flush,
  input  logic                 kill_valid,
  input  logic [ROB_IDX_W-1:0] kill_rob_idx,
  input  logic                 in_valid,
  input  micro_opcode_t        in_uopcode,
  input  logic [19:0]          in_packed_imm,
  input  imm_type_t            in_imm_type,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 out_ready,
  output lane_state_t          state,
  output logic                 out_valid,
  output exe_ctrl_t            out_ctrl,
  output logic [31:0]          out_imm,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [PAYLOAD_W-1:0] out_payload
);
  typedef struct packed {
    exe_ctrl_t              ctrl;
    logic [31:0]            imm;
    logic [ROB_IDX_W-1:0]   rob_idx;
    logic [PAYLOAD_W-1:0]   payload;
  } entry_t;

  lane_state_t state_q, state_n;
  logic        out_valid_q, out_valid_n;
  entry_t      out_q, skid_q, dec_entry, out_src;
  logic        load_out, load_skid;
  exe_ctrl_t   dec_ctrl;
  logic [31:0] dec_imm;
  logic        in_killed, out_killed, skid_killed, out_live, out_free;

  // Opcode decode
  always_comb begin
    dec_ctrl.alufn = alu_add;
    dec_ctrl.opr2  = opr2_imm;
    dec_ctrl.brfn  = br_none;
    case (in_uopcode)
      uop_slti:  dec_ctrl.alufn = alu_slt;
      uop_sltiu: dec_ctrl.alufn = alu_sltu;
      uop_xori:  dec_ctrl.alufn = alu_xor;
      uop_ori:   dec_ctrl.alufn = alu_or;
      uop_andi:  dec_ctrl.alufn = alu_and;
      uop_slli:  dec_ctrl.alufn = alu_sll;
      uop_srli:  dec_ctrl.alufn = alu_srl;
      uop_srai:  dec_ctrl.alufn = alu_sra;
      uop_add:   dec_ctrl.opr2 = opr2_rs2;
      uop_sub:   begin dec_ctrl.alufn = alu_sub;  dec_ctrl.opr2 = opr2_rs2; end
      uop_sll:   begin dec_ctrl.alufn = alu_sll;  dec_ctrl.opr2 = opr2_rs2; end
      uop_slt:   begin dec_ctrl.alufn = alu_slt;  dec_ctrl.opr2 = opr2_rs2; end
      uop_sltu:  begin dec_ctrl.alufn = alu_sltu; dec_ctrl.opr2 = opr2_rs2; end
      uop_xor:   begin dec_ctrl.alufn = alu_xor;  dec_ctrl.opr2 = opr2_rs2; end
      uop_srl:   begin dec_ctrl.alufn = alu_srl;  dec_ctrl.opr2 = opr2_rs2; end
      uop_sra:   begin dec_ctrl.alufn = alu_sra;  dec_ctrl.opr2 = opr2_rs2; end
      uop_or:    begin dec_ctrl.alufn = alu_or;   dec_ctrl.opr2 = opr2_rs2; end
      uop_and:   begin dec_ctrl.alufn = alu_and;  dec_ctrl.opr2 = opr2_rs2; end
      uop_beq:   dec_ctrl.brfn = br_beq;
      uop_bne:   dec_ctrl.brfn = br_bne;
      uop_blt:   dec_ctrl.brfn = br_blt;
      uop_bge:   dec_ctrl.brfn = br_bge;
      uop_bltu:  dec_ctrl.brfn = br_bltu;
      uop_bgeu:  dec_ctrl.brfn = br_bgeu;
      uop_jalr:  dec_ctrl.brfn = br_jalr;
      default:   ;
    endcase
  end

  // Immediate expansion from the 20-bit packed form
  always_comb begin
    dec_imm = '0;
    case (in_imm_type)
      imm_i, imm_s: dec_imm = {{20{in_packed_imm[19]}}, in_packed_imm[19:8]};
      imm_b: dec_imm = {{19{in_packed_imm[19]}}, in_packed_imm[19], in_packed_imm[8],
                        in_packed_imm[18:9], 1'b0};
      imm_j: dec_imm = {{11{in_packed_imm[19]}}, in_packed_imm[19], in_packed_imm[7:0],
                        in_packed_imm[8], in_packed_imm[18:9], 1'b0};
      imm_u: dec_imm = {in_packed_imm, 12'b0};
      default: dec_imm = '0;
    endcase
  end

  assign dec_entry = '{ctrl: dec_ctrl, imm: dec_imm, rob_idx: in_rob_idx,
                       payload: in_payload};

  assign in_killed   = kill_valid && rob_younger(32'(in_rob_idx), 32'(kill_rob_idx),
                                                 32'(rob_head), ROB_IDX_W);
  assign out_killed  = kill_valid && rob_younger(32'(out_q.rob_idx), 32'(kill_rob_idx),
                                                 32'(rob_head), ROB_IDX_W);
  assign skid_killed = kill_valid && rob_younger(32'(skid_q.rob_idx), 32'(kill_rob_idx),
                                                 32'(rob_head), ROB_IDX_W);
  assign out_live = out_valid_q && !out_killed;
  // The output slot can take a new entry if it is empty, squashed or draining
  assign out_free = !out_live || out_ready;

  always_comb begin
    state_n     = state_q;
    out_valid_n = out_valid_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    out_src     = dec_entry;
    if (flush) begin
      state_n     = lane_pass;
      out_valid_n = 1'b0;
    end else begin
      case (state_q)
        lane_pass: begin
          if (in_valid && !in_killed) begin
            if (out_free) begin
              load_out    = 1'b1;
              out_valid_n = 1'b1;
            end else begin
              load_skid = 1'b1;
              state_n   = lane_skid;
            end
          end else if (out_free) begin
            out_valid_n = 1'b0;
          end
        end
        lane_skid: begin
          if (skid_killed) begin
            state_n = lane_pass;
            if (out_free) out_valid_n = 1'b0;
          end else if (out_free) begin
            load_out    = 1'b1;
            out_src     = skid_q;
            out_valid_n = 1'b1;
            state_n     = lane_pass;
          end
        end
        default: state_n = lane_pass;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= lane_pass;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_n;
      out_valid_q <= out_valid_n;
      if (load_out)  out_q  <= out_src;
      if (load_skid) skid_q <= dec_entry;
    end
  end

  assign state       = state_q;
  assign out_valid   = out_valid_q;
  assign out_ctrl    = out_q.ctrl;
  assign out_imm     = out_q.imm;
  assign out_rob_idx = out_q.rob_idx;
  assign out_payload = out_q.payload;
endmodule

// File: rtl/exe_decode_lanes.sv
// Multi-lane registered execute-decode stage. Handshake: a transfer happens on
// any cycle where valid and ready are both high; valid never waits on ready.
module exe_decode_lanes
  import rv32i_types::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ROB_IDX_W = 5,
  parameter int PAYLOAD_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROB_IDX_W-1:0]      rob_head,
  input  logic                      flush,
  input  logic                      kill_valid,
  input  logic [ROB_IDX_W-1:0]      kill_rob_idx,
  input  logic [NUM_LANES-1:0]      in_valid,
  output logic [NUM_LANES-1:0]      in_ready,
  input  uopc::micro_opcode_t       in_uopcode    [NUM_LANES],
  input  logic [19:0]               in_packed_imm [NUM_LANES],
  input  immt::imm_type_t           in_imm_type   [NUM_LANES],
  input  logic [ROB_IDX_W-1:0]      in_rob_idx    [NUM_LANES],
  input  logic [PAYLOAD_W-1:0]      in_payload    [NUM_LANES],
  output logic [NUM_LANES-1:0]      out_valid,
  input  logic [NUM_LANES-1:0]      out_ready,
  output exe_ctrl_t                 out_ctrl      [NUM_LANES],
  output logic [31:0]               out_imm       [NUM_LANES],
  output logic [ROB_IDX_W-1:0]      out_rob_idx   [NUM_LANES],
  output logic [PAYLOAD_W-1:0]      out_payload   [NUM_LANES]
);
  lane_state_t lane_state [NUM_LANES];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    exe_dec_lane #(
      .ROB_IDX_W (ROB_IDX_W),
      .PAYLOAD_W (PAYLOAD_W)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .rob_head      (rob_head),
      .flush         (flush),
      .kill_valid    (kill_valid),
      .kill_rob_idx  (kill_rob_idx),
      .in_valid      (in_valid[l]),
      .in_uopcode    (in_uopcode[l]),
      .in_packed_imm (in_packed_imm[l]),
      .in_imm_type   (in_imm_type[l]),
      .in_rob_idx    (in_rob_idx[l]),
      .in_payload    (in_payload[l]),
      .out_ready     (out_ready[l]),
      .state         (lane_state[l]),
      .out_valid     (out_valid[l]),
      .out_ctrl      (out_ctrl[l]),
      .out_imm       (out_imm[l]),
      .out_rob_idx   (out_rob_idx[l]),
      .out_payload   (out_payload[l])
    );
    // in_ready is a pure decode of the lane state flop
    assign in_ready[l] = (lane_state[l] == lane_pass);
  end
endmodule

// File: tb/tb_exe_decode_lanes.sv
// Bench for exe_decode_lanes: directed checks with literal expectations plus
// randomized traffic compared every cycle against a per-lane queue model.
module tb_exe_decode_lanes;
  import rv32i_types::*;
  import uopc::*;
  import immt::*;
  import alufnt::*;
  import opr2t::*;
  import brfnt::*;

  localparam int NL = 4;
  localparam int RW = 5;
  localparam int PW = 64;
  localparam int EW = 8 + 32 + RW + PW;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] rob_head;
  logic flush, kill_valid;
  logic [RW-1:0] kill_rob_idx;
  logic [NL-1:0] in_valid, in_ready, out_valid, out_ready;
  micro_opcode_t in_uopcode [NL];
  logic [19:0]   in_packed_imm [NL];
  imm_type_t     in_imm_type [NL];
  logic [RW-1:0] in_rob_idx [NL];
  logic [PW-1:0] in_payload [NL];
  exe_ctrl_t     out_ctrl [NL];
  logic [31:0]   out_imm [NL];
  logic [RW-1:0] out_rob_idx [NL];
  logic [PW-1:0] out_payload [NL];

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q [NL][$];
  logic [EW-1:0] keep_q [$];

  exe_decode_lanes #(.NUM_LANES(NL), .ROB_IDX_W(RW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .rob_head(rob_head), .flush(flush),
    .kill_valid(kill_valid), .kill_rob_idx(kill_rob_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_uopcode(in_uopcode),
    .in_packed_imm(in_packed_imm), .in_imm_type(in_imm_type),
    .in_rob_idx(in_rob_idx), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_imm(out_imm), .out_rob_idx(out_rob_idx), .out_payload(out_payload)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic exe_ctrl_t model_ctrl(micro_opcode_t op);
    exe_ctrl_t c;
    c.alufn = alu_add; c.opr2 = opr2_imm; c.brfn = br_none;
    case (op)
      uop_slti, uop_slt:   c.alufn = alu_slt;
      uop_sltiu, uop_sltu: c.alufn = alu_sltu;
      uop_xori, uop_xor:   c.alufn = alu_xor;
      uop_ori, uop_or:     c.alufn = alu_or;
      uop_andi, uop_and:   c.alufn = alu_and;
      uop_slli, uop_sll:   c.alufn = alu_sll;
      uop_srli, uop_srl:   c.alufn = alu_srl;
      uop_srai, uop_sra:   c.alufn = alu_sra;
      uop_sub:             c.alufn = alu_sub;
      default:             c.alufn = alu_add;
    endcase
    if (op inside {uop_add, uop_sub, uop_sll, uop_slt, uop_sltu, uop_xor,
                   uop_srl, uop_sra, uop_or, uop_and})
      c.opr2 = opr2_rs2;
    case (op)
      uop_beq:  c.brfn = br_beq;
      uop_bne:  c.brfn = br_bne;
      uop_blt:  c.brfn = br_blt;
      uop_bge:  c.brfn = br_bge;
      uop_bltu: c.brfn = br_bltu;
      uop_bgeu: c.brfn = br_bgeu;
      uop_jalr: c.brfn = br_jalr;
      default:  c.brfn = br_none;
    endcase
    return c;
  endfunction

  // Immediate value computed as a signed offset, then taken mod 2^32
  function automatic logic [31:0] model_imm(logic [19:0] p, imm_type_t t);
    longint v;
    longint s;
    s = longint'(p[19]);
    case (t)
      imm_i, imm_s: begin
        v = longint'(p >> 8);
        if (v >= 2048) v = v - 4096;
      end
      imm_b: begin
        v = s * 4096 + longint'(p[8]) * 2048 + longint'(p[18:9]) * 2;
        if (s != 0) v = v - 8192;
      end
      imm_j: begin
        v = s * (64'd1 << 20) + longint'(p[7:0]) * 4096 + longint'(p[8]) * 2048
            + longint'(p[18:9]) * 2;
        if (s != 0) v = v - (64'd1 << 21);
      end
      imm_u:   v = longint'(p) * 4096;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic int age(int x, int h);
    return (x - h + 32) % 32;
  endfunction

  function automatic bit killed_now(logic [RW-1:0] idx);
    return kill_valid && (age(int'(idx), int'(rob_head)) > age(int'(kill_rob_idx), int'(rob_head)));
  endfunction

  function automatic logic [EW-1:0] mk_entry(int l);
    return {model_ctrl(in_uopcode[l]), model_imm(in_packed_imm[l], in_imm_type[l]),
            in_rob_idx[l], in_payload[l]};
  endfunction

  // Each lane holds at most two ops in age order; the head is what is presented
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) exp_q[l].delete();
    end else begin
      for (int l = 0; l < NL; l++) begin
        bit rdy, pop;
        if (flush) begin
          exp_q[l].delete();
        end else begin
          rdy = exp_q[l].size() < 2;
          pop = (exp_q[l].size() > 0) && out_ready[l] && !killed_now(exp_q[l][0][PW +: RW]);
          keep_q.delete();
          foreach (exp_q[l][i])
            if (!killed_now(exp_q[l][i][PW +: RW])) keep_q.push_back(exp_q[l][i]);
          if (pop) void'(keep_q.pop_front());
          if (in_valid[l] && rdy && !killed_now(in_rob_idx[l])) keep_q.push_back(mk_entry(l));
          exp_q[l] = keep_q;
        end
      end
    end
  end

  // Scoreboard: compare every lane on every falling edge outside reset
  always @(negedge clk) begin
    if (!rst) begin
      for (int l = 0; l < NL; l++) begin
        logic e_v, e_r;
        logic [EW-1:0] got, want;
        e_v  = exp_q[l].size() > 0;
        e_r  = exp_q[l].size() < 2;
        want = e_v ? exp_q[l][0] : '0;
        got  = {out_ctrl[l], out_imm[l], out_rob_idx[l], out_payload[l]};
        n_tests++;
        if (out_valid[l] !== e_v || in_ready[l] !== e_r || (e_v && got !== want)) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL lane%0d_cycle t=%0t: got v=%b r=%b e=%h, expected v=%b r=%b e=%h",
                     l, $time, out_valid[l], in_ready[l], got, e_v, e_r, want);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    flush = 1'b0;
    kill_valid = 1'b0;
  endtask

  task automatic set_op(input int l, input micro_opcode_t op, input logic [19:0] p,
                        input imm_type_t t, input logic [RW-1:0] rob, input logic [PW-1:0] pl);
    in_valid[l] = 1'b1;
    in_uopcode[l] = op;
    in_packed_imm[l] = p;
    in_imm_type[l] = t;
    in_rob_idx[l] = rob;
    in_payload[l] = pl;
  endtask

  task automatic rand_lane(input int l);
    set_op(l, micro_opcode_t'($urandom_range(0, 31)), 20'($urandom),
           imm_type_t'($urandom_range(0, 4)), RW'($urandom), {$urandom, $urandom});
    in_valid[l] = ($urandom_range(0, 9) < 7);
  endtask

  exe_ctrl_t add_imm_none;

  initial begin
    add_imm_none = '{alufn: alu_add, opr2: opr2_imm, brfn: br_none};
    rst = 1'b1;
    rob_head = '0;
    kill_rob_idx = '0;
    out_ready = '1;
    idle();
    for (int l = 0; l < NL; l++) set_op(l, uop_nop, '0, imm_i, '0, '0);
    in_valid = '0;
    repeat (2) tick();
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'hF);
    chk("reset_out_imm0", 64'(out_imm[0]), 64'h0);
    chk("reset_out_ctrl1", 64'(out_ctrl[1]), 64'h0);
    chk("reset_out_payload3", out_payload[3], 64'h0);
    rst = 1'b0;

    // Traffic, then an asynchronous reset in the middle of it
    out_ready = '0;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < NL; l++) rand_lane(l);
      tick();
    end
    idle();
    #1 rst = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'h0);
    chk("midreset_in_ready", 64'(in_ready), 64'hF);
    rst = 1'b0;
    out_ready = '1;

    // addi, i-type all ones
    set_op(0, uop_addi, 20'hFFF00, imm_i, 5'd3, 64'hA);
    tick(); idle();
    chk("addi_valid", 64'(out_valid[0]), 64'h1);
    chk("addi_ctrl", 64'(out_ctrl[0]), 64'(add_imm_none));
    chk("addi_imm", 64'(out_imm[0]), 64'hFFFFFFFF);

    // beq, b-type
    set_op(1, uop_beq, 20'h80100, imm_b, 5'd4, 64'hB);
    tick(); idle();
    chk("beq_brfn", 64'(out_ctrl[1].brfn), 64'(br_beq));
    chk("beq_imm", 64'(out_imm[1]), 64'hFFFFF800);
    tick();

    // Skid: two ops against a stalled consumer, then drain in order
    out_ready = '0;
    set_op(0, uop_add, 20'h00001, imm_i, 5'd5, 64'h5);
    tick();
    set_op(0, uop_sub, 20'h00002, imm_i, 5'd6, 64'h6);
    tick(); idle();
    chk("skid_in_ready_low", 64'(in_ready[0]), 64'h0);
    chk("skid_out_first", 64'(out_rob_idx[0]), 64'd5);
    tick();
    chk("skid_hold_stable", 64'(out_rob_idx[0]), 64'd5);
    out_ready[0] = 1'b1;
    tick();
    chk("skid_drain_second", 64'(out_rob_idx[0]), 64'd6);
    chk("skid_in_ready_back", 64'(in_ready[0]), 64'h1);
    tick();
    chk("skid_drained", 64'(out_valid[0]), 64'h0);

    // Kill with wrapped ages: head 30, kill at 31, index 1 is younger
    out_ready = '0;
    rob_head = 5'd30;
    set_op(2, uop_addi, 20'h0, imm_i, 5'd1, 64'h21);
    set_op(3, uop_addi, 20'h0, imm_i, 5'd31, 64'h31);
    tick();
    set_op(2, uop_addi, 20'h0, imm_i, 5'd31, 64'h22);
    set_op(3, uop_addi, 20'h0, imm_i, 5'd1, 64'h32);
    tick(); idle();
    kill_valid = 1'b1;
    kill_rob_idx = 5'd31;
    tick(); idle();
    chk("kill_out_valid", 64'(out_valid), 64'hC);
    chk("kill_promote_rob", 64'(out_rob_idx[2]), 64'd31);
    chk("kill_promote_payload", out_payload[2], 64'h22);
    chk("kill_keep_rob", 64'(out_rob_idx[3]), 64'd31);
    chk("kill_in_ready", 64'(in_ready), 64'hF);

    // Flush while every lane offers an op
    for (int l = 0; l < NL; l++) set_op(l, uop_ori, 20'h12300, imm_i, 5'd7, 64'h7);
    tick();
    for (int l = 0; l < NL; l++) set_op(l, uop_ori, 20'h45600, imm_i, 5'd8, 64'h8);
    flush = 1'b1;
    tick(); idle();
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'hF);
    tick();
    chk("flush_no_capture", 64'(out_valid), 64'h0);

    // Saturation: lui on all lanes at full rate
    out_ready = '1;
    rob_head = '0;
    for (int c = 0; c < 6; c++) begin
      for (int l = 0; l < NL; l++) set_op(l, uop_lui, 20'h12345, imm_u, RW'(c), 64'(c));
      tick();
      chk("sat_valid", 64'(out_valid), 64'hF);
      chk("sat_ready", 64'(in_ready), 64'hF);
      for (int l = 0; l < NL; l++) chk("sat_imm", 64'(out_imm[l]), 64'h12345000);
      chk("sat_ctrl", 64'(out_ctrl[2]), 64'(add_imm_none));
    end
    idle();
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < NL; l++) rand_lane(l);
      out_ready = NL'($urandom);
      kill_valid = ($urandom_range(0, 7) == 0);
      kill_rob_idx = RW'($urandom);
      flush = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) rob_head = RW'($urandom);
      if (c == 1500) begin
        #1 rst = 1'b1;
        #1;
        chk("rand_midreset", 64'(out_valid), 64'h0);
        rst = 1'b0;
      end
      tick();
    end
    idle();
    out_ready = '1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exe_decode_lanes.md
# exe_decode_lanes

Multi-lane, registered execute-decode stage between register read and the functional units. Each lane takes one issued micro-op, expands its opcode into ALU/branch control and its packed 20-bit immediate into a full 32-bit immediate, then presents the result to its functional unit through a valid/ready handshake. Each lane has a one-entry skid buffer, so `in_ready` is a registered signal. Entries younger than a resolving branch are squashed in place.

## Interface
Parameters:
- `NUM_LANES`, 4: number of independent lanes.
- `ROB_IDX_W`, 5: ROB index width.
- `PAYLOAD_W`, 64: opaque pass-through bits (operand data, destination tag).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `rob_head`  in  ROB_IDX_W  current oldest ROB index, used for age compare.
- `flush`  in  1  drop every held entry.
- `kill_valid`  in  1  branch mispredict resolved this cycle.
- `kill_rob_idx`  in  ROB_IDX_W  ROB index of the mispredicted branch.
- `in_valid`  in  [NUM_LANES]  per-lane input valid.
- `in_ready`  out  [NUM_LANES]  per-lane ready; registered.
- `in_uopcode`  in  [NUM_LANES] uopc::micro_opcode_t  micro-opcode.
- `in_packed_imm`  in  [NUM_LANES][20]  packed immediate.
- `in_imm_type`  in  [NUM_LANES] immt::imm_type_t  immediate format.
- `in_rob_idx`  in  [NUM_LANES][ROB_IDX_W]  ROB index of the op.
- `in_payload`  in  [NUM_LANES][PAYLOAD_W]  pass-through data.
- `out_valid`  out  [NUM_LANES]  decoded op valid.
- `out_ready`  in  [NUM_LANES]  functional unit accepts.
- `out_ctrl`  out  [NUM_LANES] exe_ctrl_t  `{alufn, opr2, brfn}`.
- `out_imm`  out  [NUM_LANES][32]  expanded immediate.
- `out_rob_idx`  out  [NUM_LANES][ROB_IDX_W]  ROB index of the output op.
- `out_payload`  out  [NUM_LANES][PAYLOAD_W]  pass-through data.

## Operation
- Lanes are fully independent; they share only `flush`, `kill_*` and `rob_head`.
- ALU decode:
  - I-type ops (lui, addi, slti, sltiu, xori, ori, andi, slli, srli, srai) select opr2 = imm.
  - R-type ops select opr2 = rs2.
  - lui decodes to add/imm.
  - Every other opcode decodes to add/imm.
- Branch decode:
  - beq, bne, blt, bge, bltu and bgeu map 1:1 to brfn.
  - jalr maps to jalr.
  - All other opcodes map to none.
- Immediate expansion; p = packed, s = p[19]:
  - i, s: sign-extend p[19:8].
  - b: {19×s, s, p[8], p[18:9], 0}.
  - j: {11×s, s, p[7:0], p[8], p[18:9], 0}.
  - u: {p[19:0], 12'b0}.
- Age: `age(x) = (x − rob_head) mod 2^ROB_IDX_W`. An entry is killed when `kill_valid` is high and `age(entry) > age(kill_rob_idx)`. The branch itself survives, as does any op with equal age.
- Each lane has two states, derived from the skid-valid bit:
  - PASS (skid empty, `in_ready` = 1):
    - An input is accepted when `in_valid` is high.
    - The decoded op loads the output register if the output register is empty or `out_ready` is high.
    - Otherwise it loads the skid entry, and the lane moves to SKID.
  - SKID (`in_ready` = 0): when `out_ready` is high, the skid entry moves to the output register and the lane returns to PASS.
- Decode happens before capture; both the output register and the skid entry hold decoded fields.
- Priority per cycle: `rst` > `flush` > kill > normal flow.
  - `flush` clears both valid bits. No input is captured that cycle.
  - Kill clears each held entry that meets the kill condition.
  - An incoming op that meets the kill condition is not captured, but it is still handshaken: `in_valid & in_ready` counts as consumed.
  - A killed skid entry returns the lane to PASS.
- Killing the output register while a surviving skid entry exists promotes the skid entry the same cycle.

## Timing
- Latency is 1 cycle from input handshake to `out_valid`.
- Full throughput when `out_ready` is held high.
- Reset values: `out_valid` = 0, `in_ready` = 1, all data outputs = 0, skid empty.
- `in_ready` depends only on state, never combinationally on `out_ready`.
- `out_*` are held stable while `out_valid & ~out_ready`, unless a flush or kill clears the entry.
- Reset asserted mid-operation discards all entries immediately (asynchronous).
- Age compare wraps at 2^ROB_IDX_W. With `rob_head` = 30 and ROB_IDX_W = 5, index 1 is younger than index 31.

## Structure
- Shared package `rv32i_types` gains:
  - `exe_ctrl_t` struct (`alufnt::alu_func_t alufn`, `opr2t::operand2_t opr2`, `brfnt::br_func_t brfn`).
  - `rob_younger()` age-compare function.
- Sub-module `exe_dec_lane`: one lane, holding the decode, immediate expansion, output register and skid buffer. The top level instantiates `NUM_LANES` copies with a generate loop.

## Test plan
- Reset mid-stream, then lane 0 gets addi with p = 20'hFFF00 (i) -> next cycle `out_ctrl` = {add, imm, none}, `out_imm` = 32'hFFFFFFFF.
- Lane 1 gets beq with b-type p = 20'h80100 -> brfn = beq, `out_imm` = 32'hFFFFF800.
- Hold `out_ready` = 0 and send two ops -> second op goes to skid and `in_ready` = 0. Raise `out_ready` -> ops drain in order and `in_ready` returns to 1 one cycle later.
- `rob_head` = 30, held ROB indices 31 and 1, kill at 31 -> the idx-1 entry is dropped, the idx-31 entry is kept, and the skid entry is promoted if applicable.
- `flush` together with `in_valid` on all lanes -> all `out_valid` = 0 next cycle and nothing is captured.
- Saturate all 4 lanes with lui, u-type p = 20'h12345, and `out_ready` = 1 -> each lane outputs imm 32'h12345000 every cycle at one op per cycle.
